ram_port_arbiter: RTL

//  Shares the single data-RAM port between two requesters: port 0 = stack CPU core,

---
 rtl/mem_map_pkg.sv | 24 ++
 rtl/rd_tag_pipe.sv | 31 +++
 rtl/ram_port_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mem_map_pkg.sv
// Shared memory map, port ids, arbiter states and read-tag bundle
// for the data-RAM port arbiter.
package mem_map_pkg;

  localparam logic [15:0] INPUT_BEGIN = 16'h0000;
  localparam logic [15:0] SEG1_BEGIN  = 16'h0001;
  localparam logic [15:0] STACK_BEGIN = 16'h0003;

  typedef logic [0:0] port_id_t;

  typedef enum logic [1:0] {
    IDLE,
    LOCK0,
    LOCK1
  } arb_state_t;

  typedef struct packed {
    logic        valid;
    port_id_t    port;
    logic        mmio_sel;
    logic [15:0] mmio_data;
  } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Fixed-depth shift register carrying read tags from accept to return.
// Ports: clk_i, rst_ni (async clear), tag_i (accepted beat), tag_o (return).
module rd_tag_pipe
  import mem_map_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t pipe_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-master data-RAM port arbiter with MMIO decode and tagged reads.
// Ports: clock/reset_n, per-port req/we/lock/addr/wdata in, gnt/rvalid out,
// rdata out, registered RAM port (ram_addr/ram_data/ram_wren, ram_q in),
// sw_in switch word in, seg1/seg2 display registers out.
module ram_port_arbiter #(
  parameter int          RD_LAT      = 2,
  parameter logic [15:0] INPUT_BEGIN = mem_map_pkg::INPUT_BEGIN,
  parameter logic [15:0] SEG1_BEGIN  = mem_map_pkg::SEG1_BEGIN
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic        lock0,
  input  logic        lock1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [15:0] rdata,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_data,
  output logic        ram_wren,
  input  logic [15:0] ram_q,
  input  logic [15:0] sw_in,
  output logic [15:0] seg1,
  output logic [15:0] seg2
);

  import mem_map_pkg::*;

  localparam int          DEPTH     = 1 + RD_LAT;
  localparam logic [15:0] SEG2_ADDR = SEG1_BEGIN + 16'd1;

  arb_state_t  state_q;
  port_id_t    last_q;
  logic [15:0] ram_addr_q, ram_data_q;
  logic        ram_wren_q;
  logic [15:0] seg1_q, seg2_q;

  logic        acc0, acc1, acc;
  port_id_t    b_port;
  logic        b_we;
  logic [15:0] b_addr, b_wdata;
  logic        is_in, is_s1, is_s2, is_mmio;
  logic [15:0] mmio_rd;
  rd_tag_t     tag_d, tag_q;

  // While locked, the owner's req alone decides; once it lets go the
  // other port can be served in the same cycle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (state_q)
      LOCK0: begin
        gnt0 = req0;
        gnt1 = !req0 & req1;
      end
      LOCK1: begin
        gnt1 = req1;
        gnt0 = !req1 & req0;
      end
      default: begin
        gnt0 = req0 & (!req1 | (last_q == 1'b1));
        gnt1 = req1 & (!req0 | (last_q == 1'b0));
      end
    endcase
  end

  assign acc0    = req0 & gnt0;
  assign acc1    = req1 & gnt1;
  assign acc     = acc0 | acc1;
  assign b_port  = port_id_t'(acc1);
  assign b_we    = acc1 ? we1 : we0;
  assign b_addr  = acc1 ? addr1 : addr0;
  assign b_wdata = acc1 ? wdata1 : wdata0;

  assign is_in   = (b_addr == INPUT_BEGIN);
  assign is_s1   = (b_addr == SEG1_BEGIN);
  assign is_s2   = (b_addr == SEG2_ADDR);
  assign is_mmio = is_in | is_s1 | is_s2;

  always_comb begin
    mmio_rd = 16'h0000;
    unique case (1'b1)
      is_in:   mmio_rd = sw_in;
      is_s1:   mmio_rd = seg1_q;
      is_s2:   mmio_rd = seg2_q;
      default: mmio_rd = 16'h0000;
    endcase
  end

  always_comb begin
    tag_d           = '0;
    tag_d.valid     = acc & !b_we;
    tag_d.port      = b_port;
    tag_d.mmio_sel  = is_mmio;
    tag_d.mmio_data = mmio_rd;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      if (acc) begin
        last_q <= b_port;
      end
      unique case (state_q)
        IDLE: begin
          if (acc0 & lock0) state_q <= LOCK0;
          else if (acc1 & lock1) state_q <= LOCK1;
        end
        LOCK0: begin
          if (!req0) state_q <= (acc1 & lock1) ? LOCK1 : IDLE;
          else if (!lock0) state_q <= IDLE;
        end
        LOCK1: begin
          if (!req1) state_q <= (acc0 & lock0) ? LOCK0 : IDLE;
          else if (!lock1) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr_q <= 16'h0000;
      ram_data_q <= 16'h0000;
      ram_wren_q <= 1'b0;
      seg1_q     <= 16'h0000;
      seg2_q     <= 16'h0000;
    end else begin
      ram_wren_q <= 1'b0;
      if (acc & !is_mmio) begin
        ram_addr_q <= b_addr;
        ram_data_q <= b_wdata;
        ram_wren_q <= b_we;
      end
      if (acc & b_we & is_s1) seg1_q <= b_wdata;
      if (acc & b_we & is_s2) seg2_q <= b_wdata;
    end
  end

  rd_tag_pipe #(
    .DEPTH(DEPTH)
  ) u_tags (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .tag_i  (tag_d),
    .tag_o  (tag_q)
  );

  assign rvalid0  = tag_q.valid & (tag_q.port == 1'b0);
  assign rvalid1  = tag_q.valid & (tag_q.port == 1'b1);
  assign rdata    = !tag_q.valid ? 16'h0000 :
                    tag_q.mmio_sel ? tag_q.mmio_data : ram_q;
  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign ram_wren = ram_wren_q;
  assign seg1     = seg1_q;
  assign seg2     = seg2_q;

endmodule
